// File: rtl/da2_loop_sequencer.sv
// Control-loop sample sequencer: tick generation, PI start/done handshake and PMOD DA2 frame output.
// Optional watchdog on the PI handshake is built when DA2_WATCHDOG_EN is defined.
module da2_loop_sequencer #(
    parameter int SAMPLE_DIV = 5000,
    parameter int SCLK_HALF  = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        pi_start,
    input  logic        pi_done,
    input  logic [15:0] sat_data,
    output logic        sync_n,
    output logic        sclk,
    output logic        dina,
    output logic        busy,
    output logic        overrun,
    output logic        fault
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int SUB_W = ($clog2(2 * SCLK_HALF) < 1) ? 1 : $clog2(2 * SCLK_HALF);

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [SUB_W-1:0] SETTLE_LAST = SUB_W'(1);
    localparam logic [SUB_W-1:0] HALF_LAST   = SUB_W'(SCLK_HALF - 1);
    localparam logic [SUB_W-1:0] GAP_LAST    = SUB_W'(2 * SCLK_HALF - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_SHIFT     = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [DIV_W-1:0]   div_r;
    logic [SUB_W-1:0]   sub_r, sub_nxt_s;
    logic [4:0]         ph_r, ph_nxt_s;
    logic [15:0]        frame_r, frame_nxt_s;
    logic               tick_s;
    logic               wd_expire_s;
    logic               pi_start_r, sync_n_r, sclk_r, dina_r, busy_r, overrun_r;
    logic               pi_start_nxt_s, sync_n_nxt_s, sclk_nxt_s, dina_nxt_s, busy_nxt_s, overrun_nxt_s;

    // Out-of-range saturator codes are pinned to full scale.
    function automatic logic [11:0] clip_code(input logic [15:0] d);
        return (d[15:12] != 4'd0) ? 12'hFFF : d[11:0];
    endfunction

    assign tick_s = enable && (div_r == DIV_LAST);

    // Sample-period counter, parked at zero while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_r <= '0;
        end else if (!enable || (div_r == DIV_LAST)) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef DA2_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_r;
    logic            fault_r;

    // Cycles elapsed since pi_start; only meaningful in WAIT_DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_r <= '0;
        end else if (state_r == ST_START) begin
            wd_r <= {{(WD_W-1){1'b0}}, 1'b1};
        end else if (state_r == ST_WAIT_DONE) begin
            wd_r <= wd_r + {{(WD_W-1){1'b0}}, 1'b1};
        end else begin
            wd_r <= '0;
        end
    end

    assign wd_expire_s = (state_r == ST_WAIT_DONE) && !pi_done && (wd_r == WD_LAST);

    // Sticky watchdog flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= fault_r | wd_expire_s;
        end
    end

    assign fault = fault_r;
`else
    assign wd_expire_s = 1'b0;
    assign fault       = 1'b0;
`endif

    // State and sequencing counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            sub_r   <= '0;
            ph_r    <= 5'd0;
            frame_r <= 16'h0000;
        end else begin
            state_r <= state_nxt_s;
            sub_r   <= sub_nxt_s;
            ph_r    <= ph_nxt_s;
            frame_r <= frame_nxt_s;
        end
    end

    // Next-state logic; ph counts SCLK half-periods, even = high, odd = low.
    always_comb begin
        state_nxt_s = state_r;
        sub_nxt_s   = sub_r;
        ph_nxt_s    = ph_r;
        case (state_r)
            ST_IDLE: begin
                sub_nxt_s   = '0;
                ph_nxt_s    = 5'd0;
                state_nxt_s = tick_s ? ST_START : ST_IDLE;
            end
            ST_START: begin
                state_nxt_s = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                sub_nxt_s = '0;
                if (pi_done) begin
                    state_nxt_s = ST_SETTLE;
                end else if (wd_expire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_SETTLE: begin
                if (sub_r == SETTLE_LAST) begin
                    state_nxt_s = ST_SHIFT;
                    sub_nxt_s   = '0;
                    ph_nxt_s    = 5'd0;
                end else begin
                    sub_nxt_s = sub_r + {{(SUB_W-1){1'b0}}, 1'b1};
                end
            end
            ST_SHIFT: begin
                if (sub_r == HALF_LAST) begin
                    sub_nxt_s = '0;
                    if (ph_r == 5'd31) begin
                        state_nxt_s = ST_GAP;
                        ph_nxt_s    = 5'd0;
                    end else begin
                        ph_nxt_s = ph_r + 5'd1;
                    end
                end else begin
                    sub_nxt_s = sub_r + {{(SUB_W-1){1'b0}}, 1'b1};
                end
            end
            ST_GAP: begin
                if (sub_r == GAP_LAST) begin
                    state_nxt_s = ST_IDLE;
                    sub_nxt_s   = '0;
                end else begin
                    sub_nxt_s = sub_r + {{(SUB_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                sub_nxt_s   = '0;
                ph_nxt_s    = 5'd0;
            end
        endcase
    end

    // Output next-values, decoded from the upcoming state so the pins come straight off flops.
    always_comb begin
        frame_nxt_s = frame_r;
        if ((state_r == ST_SETTLE) && (sub_r == SETTLE_LAST)) begin
            frame_nxt_s = {4'b0000, clip_code(sat_data)};
        end else begin
            frame_nxt_s = frame_r;
        end
        pi_start_nxt_s = (state_nxt_s == ST_START);
        busy_nxt_s     = (state_nxt_s != ST_IDLE);
        sync_n_nxt_s   = (state_nxt_s != ST_SHIFT);
        sclk_nxt_s     = (state_nxt_s == ST_SHIFT) ? ~ph_nxt_s[0] : 1'b1;
        dina_nxt_s     = (state_nxt_s == ST_SHIFT) ? frame_nxt_s[4'd15 - ph_nxt_s[4:1]] : 1'b0;
        overrun_nxt_s  = overrun_r | (tick_s && (state_r != ST_IDLE));
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pi_start_r <= 1'b0;
            sync_n_r   <= 1'b1;
            sclk_r     <= 1'b1;
            dina_r     <= 1'b0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            pi_start_r <= pi_start_nxt_s;
            sync_n_r   <= sync_n_nxt_s;
            sclk_r     <= sclk_nxt_s;
            dina_r     <= dina_nxt_s;
            busy_r     <= busy_nxt_s;
            overrun_r  <= overrun_nxt_s;
        end
    end

    assign pi_start = pi_start_r;
    assign sync_n   = sync_n_r;
    assign sclk     = sclk_r;
    assign dina     = dina_r;
    assign busy     = busy_r;
    assign overrun  = overrun_r;

endmodule

// File: tb/tb_da2_loop_sequencer.sv
// Directed/randomised bench for da2_loop_sequencer; DAC frames are decoded off the pins and
// compared with a clip-and-frame reference. Watchdog steps are built with DA2_WATCHDOG_EN.
module tb_da2_loop_sequencer;

    localparam int SD = 128;
    localparam int H  = 2;
    localparam int TO = 32;

    logic        clk = 1'b0;
    logic        reset, enable, pi_done;
    logic [15:0] sat_data;
    logic        pi_start, sync_n, sclk, dina, busy, overrun, fault;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    da2_loop_sequencer #(.SAMPLE_DIV(SD), .SCLK_HALF(H), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pi_start(pi_start),
        .pi_done(pi_done), .sat_data(sat_data), .sync_n(sync_n), .sclk(sclk),
        .dina(dina), .busy(busy), .overrun(overrun), .fault(fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pin-level DAC decoder: frames are rebuilt from dina at each sclk fall inside a SYNC window.
    logic        prev_sync = 1'b1, prev_sclk = 1'b1;
    int          mon_fall_cyc = 0, mon_first_off = -1, mon_falls = 0, mon_frames = 0;
    int          mon_last_falls = 0, mon_last_low = 0, mon_last_first = 0, mon_rise_cyc = 0;
    int          mon_sync_falls = 0, mon_pi_starts = 0;
    logic [15:0] mon_word = 16'h0, mon_last_word = 16'h0;

    always @(negedge clk) begin
        if (prev_sync && !sync_n) begin
            mon_fall_cyc = cyc; mon_falls = 0; mon_word = 16'h0; mon_first_off = -1;
            mon_sync_falls++;
        end
        if (!sync_n && prev_sclk && !sclk) begin
            if (mon_falls == 0) mon_first_off = cyc - mon_fall_cyc;
            mon_word = {mon_word[14:0], dina};
            mon_falls++;
        end
        if (!prev_sync && sync_n) begin
            mon_last_word = mon_word; mon_last_falls = mon_falls;
            mon_last_low = cyc - mon_fall_cyc; mon_last_first = mon_first_off;
            mon_rise_cyc = cyc; mon_frames++;
        end
        if (pi_start === 1'b1) mon_pi_starts++;
        prev_sync = sync_n;
        prev_sclk = sclk;
    end

    function automatic logic [15:0] exp_frame(input logic [15:0] d);
        int v;
        v = d;
        if (v > 4095) v = 4095;
        return 16'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cycle(input int c);
        while (cyc < c) step();
    endtask

    task automatic wait_pi_start(input int budget, output int p);
        p = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (pi_start === 1'b1) begin
                p = cyc;
                break;
            end
        end
        check("pi_start_seen", 32'(p >= 0), 32'd1);
        step();
        check("pi_start_width", 32'(pi_start), 32'd0);
        check("busy_wait_done", 32'(busy), 32'd1);
    endtask

    // Drives pi_done `delay` cycles after pi_start; sat_data is valid only in the latch cycle.
    task automatic run_sample(input int p, input int delay, input logic [15:0] data,
                              input bit spurious, input bit drop);
        int d, old;
        d   = p + delay;
        old = mon_frames;
        wait_cycle(d);
        pi_done = 1'b1; sat_data = ~data;
        step();
        pi_done = 1'b0; sat_data = data ^ 16'h5A5A;
        step();
        sat_data = data;
        check("sync_before_latch", 32'(sync_n), 32'd1);
        step();
        sat_data = 16'($urandom_range(0, 65535));
        check("sync_fall_cycle", 32'(mon_fall_cyc), 32'(d + 3));
        if (spurious) begin
            wait_cycle(d + 10);
            pi_done = 1'b1;
            step();
            pi_done = 1'b0;
        end
        if (drop) begin
            wait_cycle(d + 23);
            enable = 1'b0;
        end
        for (int i = 0; i < 120 && mon_frames == old; i++) step();
        check("frame_seen", 32'(mon_frames > old), 32'd1);
        check("frame_word", 32'(mon_last_word), 32'(exp_frame(data)));
        check("frame_falls", 32'(mon_last_falls), 32'd16);
        check("frame_low_len", 32'(mon_last_low), 32'(32 * H));
        check("first_fall_off", 32'(mon_last_first), 32'(H));
        wait_cycle(mon_rise_cyc + 2 * H - 1);
        check("busy_in_gap", 32'(busy), 32'd1);
        step();
        check("idle_after_gap", 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p, prev_p, r, n_exp, base, delay;
        logic [15:0] data;
        reset = 1'b0; enable = 1'b0; pi_done = 1'b0; sat_data = 16'h0; n_exp = 0;
        #1 reset = 1'b1;
        step(); step();
        check("rst_pi_start", 32'(pi_start), 32'd0);
        check("rst_sync_n", 32'(sync_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd1);
        check("rst_dina", 32'(dina), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        reset = 1'b0;
        step();
        enable = 1'b1;

        wait_pi_start(SD + 8, p);
        run_sample(p, 10, 16'd3723, 1'b0, 1'b0);
        n_exp++;
        for (int k = 0; k < 6; k++) begin
            prev_p = p;
            wait_pi_start(SD + 8, p);
            check("tick_period", 32'(p - prev_p), 32'(SD));
            if (k == 0) data = 16'h1234;
            else if (k % 2 == 1) data = 16'($urandom_range(0, 4095));
            else data = 16'($urandom_range(0, 65535));
            delay = $urandom_range(1, 20);
            run_sample(p, delay, data, k == 2, 1'b0);
            n_exp++;
        end
        check("no_overrun", 32'(overrun), 32'd0);
        check("no_fault", 32'(fault), 32'd0);
        check("frame_count", 32'(mon_sync_falls), 32'(n_exp));

`ifdef DA2_WATCHDOG_EN
        prev_p = p;
        wait_pi_start(SD + 8, p);
        check("tick_period_wd", 32'(p - prev_p), 32'(SD));
        base = mon_sync_falls;
        wait_cycle(p + TO - 1);
        check("fault_before", 32'(fault), 32'd0);
        check("busy_before", 32'(busy), 32'd1);
        step();
        check("fault_set", 32'(fault), 32'd1);
        check("busy_after_wd", 32'(busy), 32'd0);
        prev_p = p;
        wait_pi_start(SD + 8, p);
        check("restart_period", 32'(p - prev_p), 32'(SD));
        check("no_frame_on_wd", 32'(mon_sync_falls), 32'(base));
        run_sample(p, $urandom_range(1, 20), 16'($urandom_range(0, 65535)), 1'b0, 1'b0);
        n_exp++;
        check("fault_sticky", 32'(fault), 32'd1);
`else
        prev_p = p;
        wait_pi_start(SD + 8, p);
        check("tick_period_ov", 32'(p - prev_p), 32'(SD));
        wait_cycle(p + SD - 1);
        check("overrun_before", 32'(overrun), 32'd0);
        step();
        check("overrun_set", 32'(overrun), 32'd1);
        run_sample(p, 150, 16'($urandom_range(0, 65535)), 1'b0, 1'b0);
        n_exp++;
        prev_p = p;
        wait_pi_start(SD + 8, p);
        check("dropped_tick_period", 32'(p - prev_p), 32'(2 * SD));
        run_sample(p, $urandom_range(1, 20), 16'($urandom_range(0, 65535)), 1'b0, 1'b0);
        n_exp++;
        check("overrun_sticky", 32'(overrun), 32'd1);
        check("fault_tied_low", 32'(fault), 32'd0);
`endif
        check("frame_count2", 32'(mon_sync_falls), 32'(n_exp));

        // Disable mid-frame: frame completes, no further starts.
        prev_p = p;
        wait_pi_start(SD + 8, p);
        check("tick_period_dis", 32'(p - prev_p), 32'(SD));
        run_sample(p, 5, 16'($urandom_range(0, 65535)), 1'b0, 1'b1);
        n_exp++;
        base = mon_pi_starts;
        for (int i = 0; i < 3 * SD; i++) step();
        check("no_start_disabled", 32'(mon_pi_starts), 32'(base));
        check("idle_disabled", 32'(busy), 32'd0);
        check("frame_count3", 32'(mon_sync_falls), 32'(n_exp));

        // Reset mid-frame after the 5th sclk fall; code bit 11 keeps dina high there.
        enable = 1'b1;
        wait_pi_start(2 * SD, p);
        wait_cycle(p + 5);
        pi_done = 1'b1; sat_data = 16'h0FFF;
        step();
        pi_done = 1'b0;
        for (int i = 0; i < 100 && !(mon_falls == 5 && sync_n == 1'b0); i++) step();
        check("reached_5th_fall", 32'(mon_falls), 32'd5);
        check("dina_high_pre_rst", 32'(dina), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_sync_n", 32'(sync_n), 32'd1);
        check("arst_sclk", 32'(sclk), 32'd1);
        check("arst_dina", 32'(dina), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        check("arst_fault", 32'(fault), 32'd0);
        n_exp++;
        step();
        reset = 1'b0;
        r = cyc;
        wait_pi_start(SD + 8, p);
        check("first_start_after_rst", 32'(p), 32'(r + SD));
        run_sample(p, $urandom_range(1, 20), 16'($urandom_range(0, 65535)), 1'b0, 1'b0);
        n_exp++;
        check("frame_count_final", 32'(mon_sync_falls), 32'(n_exp));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/da2_loop_sequencer.md
# da2_loop_sequencer

Sequences one control-loop sample: generates the periodic sample tick, pulses the PI controller start, waits for `pi_done`, waits for the saturator's registered output, then serialises the 12-bit code to the PMOD DA2 (DAC121S101) over its 3-wire interface. It sits between the PI core plus saturator stage and the DAC pins, and is the only block that times the loop.

## Interface
- `SAMPLE_DIV`, 5000, clk cycles per sample period (≥ 64); 20 kHz at 100 MHz.
- `SCLK_HALF`, 2, clk cycles per SCLK half-period (≥ 1).
- `TIMEOUT`, 1024, max clk cycles from `pi_start` to `pi_done` (watchdog only).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  loop run enable.
- `pi_start`  out  1  one-cycle start pulse to the PI core.
- `pi_done`  in  1  one-cycle PI result-valid pulse; also feeds the saturator.
- `sat_data`  in  16  saturator output code, unsigned.
- `sync_n`  out  1  DAC SYNC, active low.
- `sclk`  out  1  DAC serial clock, idles high.
- `dina`  out  1  DAC serial data, channel A.
- `busy`  out  1  high in every state except IDLE.
- `overrun`  out  1  sticky; a tick arrived while busy.
- `fault`  out  1  sticky; watchdog expired.

## Operation
- Tick counter: counts 0..SAMPLE_DIV-1 while `enable`, one-cycle `tick` at wrap; held at 0 when `enable` low.
- States: IDLE → START → WAIT_DONE → SETTLE → SHIFT → GAP → IDLE.
- IDLE: on `tick`, go to START.
- START: assert `pi_start` for exactly one cycle, go to WAIT_DONE.
- WAIT_DONE: on `pi_done`, go to SETTLE. `pi_done` in any other state is ignored.
- SETTLE: exactly 2 cycles, covering the saturator's two register stages; latch `sat_data` on the 2nd cycle.
- Code clip: `sat_data[15:12]` nonzero → code 12'hFFF, else `sat_data[11:0]`.
- Frame: 16 bits MSB first = {2'b00 don't-care, 2'b00 normal mode, code[11:0]}.
- SHIFT: `sync_n` low. `dina` is updated on each `sclk` rising edge and is stable across the falling edge, where the DAC samples. Exactly 16 falling edges are produced; `sclk` ends high.
- GAP: `sync_n` high, `sclk` high for 2·SCLK_HALF cycles, then IDLE.
- A `tick` while not in IDLE sets `overrun`; that tick is dropped, with no queueing.
- `enable` falling mid-sequence: the current sequence completes, including the frame; no new ticks are generated.
- `overrun` and `fault` clear only on `reset`.

## Timing
- Reset values: `pi_start`=0, `sync_n`=1, `sclk`=1, `dina`=0, `busy`=0, `overrun`=0, `fault`=0, state IDLE, counter 0.
- Asserting `reset` mid-frame returns all outputs to their reset values asynchronously; the DAC sees an aborted frame, which it discards.
- `pi_start` is high in the cycle after `tick`.
- Latch cycle = `pi_done` cycle + 2.
- `sync_n` falls in the cycle after latch. First `sclk` fall occurs SCLK_HALF cycles later.
- Frame duration = 32·SCLK_HALF cycles. `sync_n` rises SCLK_HALF cycles after the 16th fall.
- All outputs are registered; no combinational paths from inputs to outputs.

## Configuration
- `DA2_WATCHDOG_EN` defined: a counter starts at `pi_start`. If `pi_done` has not arrived after TIMEOUT cycles in WAIT_DONE, set `fault` and return to IDLE with no DAC frame. The DAC holds its previous code.
- `DA2_WATCHDOG_EN` not defined: WAIT_DONE waits indefinitely; `fault` is tied 0; no counter logic is synthesised.

## Test plan
- Normal sample: SAMPLE_DIV=64, SCLK_HALF=2, `pi_done` 10 cycles after `pi_start`, `sat_data`=16'd3723 → frame 16'h0E8B on `dina`, 16 `sclk` falls, `sync_n` low for 64 cycles.
- Clip: `sat_data`=16'h1234 → code 12'hFFF, frame 16'h0FFF.
- Overrun: `pi_done` held off for 100 cycles with SAMPLE_DIV=64 → `overrun`=1 after the next tick; exactly one frame per completed sequence.
- Watchdog (macro on, TIMEOUT=32): no `pi_done` → `fault`=1 at `pi_start`+32, no `sync_n` fall, next tick restarts at START.
- Reset mid-frame: assert `reset` after the 5th `sclk` fall → `sync_n`=1, `sclk`=1, `dina`=0 immediately; `busy`=0.
- Disable: drop `enable` during SHIFT → the frame completes; no further `pi_start` pulses.
